// File: rtl/vec_seq_pkg.sv
// Shared types and default sizes for the vector ALU sequencer.
// Covers both the default build and the build with VEC_SEQ_FLUSH_EN defined.
package vec_seq_pkg;

  localparam int ELEM_W_DEF = 32;
  localparam int LANES_DEF  = 8;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } seq_state_e;

endpackage

// File: rtl/vec_alu_sequencer_if.sv
// Execute-stage handshake bundle between the operand muxes, the sequencer and the EM register.
// The flush signal exists only when VEC_SEQ_FLUSH_EN is defined.
interface vec_alu_sequencer_if
  import vec_seq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int ELEM_W = ELEM_W_DEF
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*ELEM_W-1:0] op1;
  logic [LANES*ELEM_W-1:0] op2;
  alu_op_e                 alu_ctrl;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ELEM_W-1:0] result;
  logic                    busy;

`ifdef VEC_SEQ_FLUSH_EN
  logic                    flush;

  modport master (
    output in_valid, op1, op2, alu_ctrl, out_ready, flush,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op1, op2, alu_ctrl, out_ready, flush,
    output in_ready, out_valid, result, busy
  );
`else
  modport master (
    output in_valid, op1, op2, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op1, op2, alu_ctrl, out_ready,
    output in_ready, out_valid, result, busy
  );
`endif

endinterface

// File: rtl/vec_lane_alu.sv
// One physical 32-bit lane ALU; purely combinational, wraps modulo 2^ELEM_W, no flags.
module vec_lane_alu
  import vec_seq_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  alu_op_e           op,
  output logic [ELEM_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      ADD: y = a + b;
      SUB: y = a - b;
      AND: y = a & b;
      OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Time-multiplexes PAR lane ALUs over the LANES elements of a vector op, LANES/PAR beats per op.
// Define VEC_SEQ_FLUSH_EN to add a flush input that aborts an op in flight.
module vec_alu_sequencer
  import vec_seq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int PAR    = 2
) (
  input  logic                clk,
  input  logic                reset,
  vec_alu_sequencer_if.slave  bus
);

  localparam int BEATS  = LANES / PAR;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES % PAR != 0) begin : g_par_check
    $error("vec_alu_sequencer: LANES must be a multiple of PAR");
  end

  // Beat-major packing lines up with the flat bus: element beat*PAR+p sits at [beat][p].
  typedef logic [BEATS-1:0][PAR-1:0][ELEM_W-1:0] vec_t;

  seq_state_e                  state;
  logic [BEAT_W-1:0]           beat;
  vec_t                        op1_q;
  vec_t                        op2_q;
  alu_op_e                     op_q;
  vec_t                        result_q;
  logic                        out_valid_q;
  logic                        busy_q;
  logic [PAR-1:0][ELEM_W-1:0]  lane_y;
  logic                        flush_req;
  logic                        last_beat;

`ifdef VEC_SEQ_FLUSH_EN
  assign flush_req = bus.flush;
`else
  assign flush_req = 1'b0;
`endif

  assign last_beat     = (beat == BEAT_W'(BEATS - 1));
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready & ~flush_req);
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

  for (genvar p = 0; p < PAR; p++) begin : g_lane
    vec_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
      .a  (op1_q[beat][p]),
      .b  (op2_q[beat][p]),
      .op (op_q),
      .y  (lane_y[p])
    );
  end

  // Flush wins over both the beat write and a DONE-cycle capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      beat        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_q        <= ADD;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op1_q  <= bus.op1;
            op2_q  <= bus.op2;
            op_q   <= bus.alu_ctrl;
            beat   <= '0;
            busy_q <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (flush_req) begin
            beat   <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            result_q[beat] <= lane_y;
            if (last_beat) begin
              beat        <= '0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE: begin
          if (flush_req) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            beat        <= '0;
            state       <= IDLE;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              op1_q <= bus.op1;
              op2_q <= bus.op2;
              op_q  <= bus.alu_ctrl;
              beat  <= '0;
              state <= BUSY;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Randomized self-checking bench for vec_alu_sequencer against a transaction-level model.
// Flush scenario is exercised only when VEC_SEQ_FLUSH_EN is defined.
module tb_vec_alu_sequencer;
  import vec_seq_pkg::*;

  localparam int LANES  = 8;
  localparam int ELEM_W = 32;
  localparam int PAR    = 2;
  localparam int BEATS  = LANES / PAR;
  localparam int W      = LANES * ELEM_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vec_alu_sequencer_if #(.LANES(LANES), .ELEM_W(ELEM_W)) bus ();

  vec_alu_sequencer #(.LANES(LANES), .ELEM_W(ELEM_W), .PAR(PAR)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          last_acc_cyc = 0;
  bit          check_en = 1'b0;
  bit          b2b_mode = 1'b0;
  bit          prev_ov  = 1'b0;
  int          rises[$];

  // Model: an op in flight, the edge count at which it becomes visible, and its answer.
  bit          m_active = 1'b0;
  int          m_ready_at = 0;
  logic [W-1:0] m_exp = '0;
  bit          m_done, m_taken, m_accept, m_flush;
  bit          c_ov, c_ir, c_flush;

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input alu_op_e op);
    logic [W-1:0]      r;
    logic [ELEM_W-1:0] x, y;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*ELEM_W +: ELEM_W];
      y = b[i*ELEM_W +: ELEM_W];
      case (op)
        ADD:     r[i*ELEM_W +: ELEM_W] = x + y;
        SUB:     r[i*ELEM_W +: ELEM_W] = x - y;
        AND:     r[i*ELEM_W +: ELEM_W] = x & y;
        default: r[i*ELEM_W +: ELEM_W] = x | y;
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ELEM_W +: ELEM_W] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      m_flush = 1'b0;
`ifdef VEC_SEQ_FLUSH_EN
      m_flush = m_active && bus.flush;
`endif
      m_done   = m_active && (cyc >= m_ready_at);
      m_taken  = m_done && bus.out_ready && !m_flush;
      m_accept = bus.in_valid && !m_flush && (!m_active || m_taken);
      cyc++;
      if (m_flush || m_taken) m_active = 1'b0;
      if (m_accept) begin
        m_active   = 1'b1;
        m_ready_at = cyc + BEATS;
        m_exp      = ref_alu(bus.op1, bus.op2, bus.alu_ctrl);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      c_flush = 1'b0;
`ifdef VEC_SEQ_FLUSH_EN
      c_flush = bus.flush;
`endif
      c_ov = m_active && (cyc >= m_ready_at);
      c_ir = !m_active || (c_ov && bus.out_ready && !c_flush);
      checkOutput("out_valid", W'(bus.out_valid), W'(c_ov));
      checkOutput("busy", W'(bus.busy), W'(m_active));
      checkOutput("in_ready", W'(bus.in_ready), W'(c_ir));
      if (c_ov) checkOutput("result", bus.result, m_exp);
      if (b2b_mode && bus.out_valid && !prev_ov) rises.push_back(cyc);
      prev_ov = bus.out_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input alu_op_e op, input bit hold);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.alu_ctrl = op;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", W'(acc), W'(1));
    if (!hold) bus.in_valid = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) checkOutput("valid_timeout", W'(bus.out_valid), W'(1));
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input alu_op_e op, input logic [W-1:0] exp);
    applyStimulus(a, b, op, 1'b0);
    waitValid();
    checkOutput(name, bus.result, exp);
    step(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] a, b, e;
    logic [1:0]   t;

    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.alu_ctrl  = ADD;
    bus.out_ready = 1'b0;
`ifdef VEC_SEQ_FLUSH_EN
    bus.flush     = 1'b0;
`endif

    @(negedge clk);
    checkOutput("reset_out_valid", W'(bus.out_valid), W'(0));
    checkOutput("reset_busy", W'(bus.busy), W'(0));
    checkOutput("reset_result", bus.result, '0);
    checkOutput("reset_in_ready", W'(bus.in_ready), W'(1));
    #2;
    rst_n    = 1'b1;
    check_en = 1'b1;
    step(1);

    // ADD with elem i = i and 0x10, plus the accept-to-valid latency.
    bus.out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      a[i*ELEM_W +: ELEM_W] = ELEM_W'(i);
      b[i*ELEM_W +: ELEM_W] = 32'h10;
      e[i*ELEM_W +: ELEM_W] = 32'h10 + ELEM_W'(i);
    end
    applyStimulus(a, b, ADD, 1'b0);
    waitValid();
    checkOutput("add_latency", W'(cyc - last_acc_cyc), W'(4));
    checkOutput("add_result", bus.result, e);
    step(1);

    runOp("sub_wrap", '0, {LANES{32'h1}}, SUB, {LANES{32'hFFFF_FFFF}});
    runOp("and_mask", {LANES{32'hF0F0_F0F0}}, {LANES{32'h0FF0_0FF0}}, AND, {LANES{32'h00F0_00F0}});
    runOp("or_mask", {LANES{32'hF0F0_F0F0}}, {LANES{32'h0FF0_0FF0}}, OR, {LANES{32'hFFF0_FFF0}});

    // Backpressure; also shows a per-lane carry never leaks into the next element.
    bus.out_ready = 1'b0;
    applyStimulus({(LANES/2){32'hFFFF_FFFF, 32'h7FFF_FFFF}}, {LANES{32'h1}}, ADD, 1'b0);
    waitValid();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", W'(bus.out_valid), W'(1));
      checkOutput("bp_in_ready", W'(bus.in_ready), W'(0));
      checkOutput("bp_busy", W'(bus.busy), W'(1));
      checkOutput("bp_result", bus.result, {(LANES/2){32'h0000_0000, 32'h8000_0000}});
      @(negedge clk);
    end
    step(1);
    bus.out_ready = 1'b1;
    step(1);

    // Back-to-back accepts in the DONE cycle.
    rises.delete();
    b2b_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 2'($urandom_range(0, 3));
      applyStimulus(rand_vec(), rand_vec(), alu_op_e'(t), 1'b1);
    end
    bus.in_valid = 1'b0;
    step(8);
    b2b_mode = 1'b0;
    checkOutput("b2b_count", W'(rises.size()), W'(4));
    for (int k = 1; k < rises.size(); k++)
      checkOutput("b2b_period", W'(rises[k] - rises[k-1]), W'(BEATS + 1));

    // Reset while at beat 1 of an op.
    applyStimulus(rand_vec(), rand_vec(), ADD, 1'b0);
    step(1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", W'(bus.out_valid), W'(0));
    checkOutput("midrst_result", bus.result, '0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_out_valid", W'(bus.out_valid), W'(0));
    checkOutput("postrst_result", bus.result, '0);
    checkOutput("postrst_in_ready", W'(bus.in_ready), W'(1));
    step(1);
    runOp("postrst_add", a, b, ADD, e);

`ifdef VEC_SEQ_FLUSH_EN
    // Flush at beat 2: op abandoned, nothing is presented, next op still correct.
    applyStimulus(rand_vec(), rand_vec(), SUB, 1'b0);
    step(2);
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("flush_no_valid", W'(bus.out_valid), W'(0));
    end
    step(1);
    runOp("postflush_add", a, b, ADD, e);
`endif

    for (int k = 0; k < 300; k++) begin
      t = 2'($urandom_range(0, 3));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.op1       = rand_vec();
      bus.op2       = rand_vec();
      bus.alu_ctrl  = alu_op_e'(t);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
